// File: rtl/pc_sequencer_if.sv
// Fetch handshake and decode/ALU control bundle for pc_sequencer.
//   master : the sequencer. It drives inst_req and inst_addr, and receives
//            inst_ack, the control fields (ctl_valid, branch, zero, jump,
//            imm, jaddr) and stall.
//   slave  : instruction memory plus the decode side, which drive those
//            inputs.
interface pc_sequencer_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic        ctl_valid;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] imm;
   logic [25:0] jaddr;
   logic        stall;

   modport master (
      output inst_req, inst_addr,
      input  inst_ack, ctl_valid, branch, zero, jump, imm, jaddr, stall
   );

   modport slave (
      input  inst_req, inst_addr,
      output inst_ack, ctl_valid, branch, zero, jump, imm, jaddr, stall
   );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle program-counter controller.
// It owns the PC register and runs the FETCH -> WAIT_CTL -> UPDATE sequence.
// The next PC is one of: the sequential PC+4, a branch target, or a jump target.
//   clk, reset  : clock; synchronous active-high reset
//   bus         : fetch handshake and control inputs (master side)
//   pc          : current program counter (inst_addr mirrors it)
//   pc_update   : pc commits next_pc on this cycle's edge
//   taken_count : saturating count of redirects (jumps + taken branches)
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   pc_sequencer_if.master        bus,
   output logic [31:0]           pc,
   output logic                  pc_update,
   output logic [15:0]           taken_count
);

   typedef enum logic [1:0] {FETCH = 2'd0, WAIT_CTL = 2'd1, UPDATE = 2'd2} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q, pc_plus4, next_pc, target;
   logic        redirect;      // latched "source was jump or taken branch"
   logic [15:0] taken_q;

   // Next-PC selection. Shifting imm left by 2 inside 32 bits discards
   // imm[31:30]; the add wraps naturally.
   always_comb begin
      if (bus.jump)
         target = {pc_plus4[31:28], bus.jaddr, 2'b00};
      else if (bus.branch && bus.zero)
         target = pc_plus4 + (bus.imm << 2);
      else
         target = pc_plus4;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= FETCH;
         pc_q     <= RESET_PC;
         pc_plus4 <= 32'h0;
         next_pc  <= 32'h0;
         redirect <= 1'b0;
         taken_q  <= 16'h0;
      end else begin
         state <= state_nxt;
         case (state)
            FETCH:
               if (bus.inst_ack) pc_plus4 <= pc_q + 32'd4;
            WAIT_CTL:
               if (bus.ctl_valid) begin
                  next_pc  <= target;
                  redirect <= bus.jump | (bus.branch & bus.zero);
               end
            UPDATE:
               if (!bus.stall) begin
                  pc_q <= next_pc;
                  if (redirect && taken_q != 16'hFFFF) taken_q <= taken_q + 16'd1;
               end
            default: ;
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:    if (bus.inst_ack)  state_nxt = WAIT_CTL;
         WAIT_CTL: if (bus.ctl_valid) state_nxt = UPDATE;
         UPDATE:   if (!bus.stall)    state_nxt = FETCH;
         default:  state_nxt = FETCH;
      endcase
   end

   // Outputs are decoded from the registered state. Only pc_update also
   // looks at stall, because a stalled UPDATE cycle must not commit.
   always_comb begin
      bus.inst_req  = (state == FETCH);
      pc_update     = (state == UPDATE) && !bus.stall;
   end

   assign bus.inst_addr  = pc_q;
   assign pc             = pc_q;
   assign taken_count    = taken_q;

endmodule
